// File: rtl/reg_scoreboard_pkg.sv
// Shared constants and types for the register write-reservation scoreboard.
package reg_scoreboard_pkg;

  localparam int SB_NREG     = 32;
  localparam int SB_CNT_W    = 2;
  localparam int CREG_ADDR_W = 5;

  typedef logic [CREG_ADDR_W-1:0] creg_addr_t;
  typedef logic [SB_CNT_W-1:0]    sb_cnt_t;

endpackage

// File: rtl/reg_scoreboard_sb_entry.sv
// One tracked register: outstanding-write counter, newest-is-load flag and
// underflow detection. The counter saturates at zero instead of wrapping.
module sb_entry
  import reg_scoreboard_pkg::*;
#(
  parameter int CNT_W = SB_CNT_W
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             inc,
  input  logic             dec_wb,
  input  logic             dec_kill,
  input  logic             issue_load,
  output logic [CNT_W-1:0] cnt,
  output logic [CNT_W-1:0] cnt_next,
  output logic             ld,
  output logic             underflow
);

  // Two guard bits: one for the +1 headroom, one for the sign.
  localparam int SUM_W = CNT_W + 2;

  logic signed [SUM_W-1:0] sum;

  // Clamp a signed net count into the unsigned counter range (negative -> 0).
  function automatic logic [CNT_W-1:0] sat_cnt(input logic signed [SUM_W-1:0] v);
    if (v[SUM_W-1]) return '0;
    return v[CNT_W-1:0];
  endfunction

  // Net arithmetic of reserve / writeback / squash landing in the same cycle.
  always_comb begin
    sum = $signed({2'b00, cnt})
        + $signed({{(SUM_W-1){1'b0}}, inc})
        - $signed({{(SUM_W-1){1'b0}}, dec_wb})
        - $signed({{(SUM_W-1){1'b0}}, dec_kill});
    underflow = sum[SUM_W-1];
    cnt_next  = sat_cnt(sum);
  end

  // Counter and load flag; the flag only means something while the count is non-zero.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0;
      ld  <= 1'b0;
    end else begin
      cnt <= cnt_next;
      if (cnt_next == '0) ld <= 1'b0;
      else if (inc)       ld <= issue_load;
    end
  end

endmodule

// File: rtl/reg_scoreboard.sv
// Per-register write-reservation tracker. Decode reserves a destination on
// issue, writeback or squash releases it, and two source ports report whether
// a reservation (and whether a load's) is outstanding. x0 is never tracked.
module reg_scoreboard
  import reg_scoreboard_pkg::*;
#(
  parameter int NREG  = SB_NREG,
  parameter int CNT_W = SB_CNT_W
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       issue_valid,
  input  logic [4:0] issue_wa,
  input  logic       issue_load,
  output logic       issue_ready,
  input  logic       wb_valid,
  input  logic [4:0] wb_wa,
  input  logic       kill_valid,
  input  logic [4:0] kill_wa,
  input  logic [4:0] ra1,
  input  logic [4:0] ra2,
  output logic       busy1,
  output logic       busy2,
  output logic       ldpend1,
  output logic       ldpend2,
  output logic       drained,
  output logic       underflow_seen
);

  // Wide enough for every register sitting at its maximum count.
  localparam int TOT_W = CNT_W + 5;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [NREG-1:0][CNT_W-1:0] cnt;
  logic [NREG-1:0][CNT_W-1:0] cnt_next;
  logic [NREG-1:0]            ld;
  logic [NREG-1:0]            underflow_vec;
  logic [TOT_W-1:0]           total;
  logic [TOT_W-1:0]           total_next;

  for (genvar r = 0; r < NREG; r++) begin : g_reg
    if (r == 0) begin : g_x0
      assign cnt[r]           = '0;
      assign cnt_next[r]      = '0;
      assign ld[r]            = 1'b0;
      assign underflow_vec[r] = 1'b0;
    end else begin : g_ent
      logic inc;
      logic dec_wb;
      logic dec_kill;

      assign inc      = issue_valid & issue_ready & (issue_wa == creg_addr_t'(r));
      assign dec_wb   = wb_valid   & (wb_wa   == creg_addr_t'(r));
      assign dec_kill = kill_valid & (kill_wa == creg_addr_t'(r));

      sb_entry #(.CNT_W(CNT_W)) u_entry (
        .clk        (clk),
        .reset_n    (reset_n),
        .inc        (inc),
        .dec_wb     (dec_wb),
        .dec_kill   (dec_kill),
        .issue_load (issue_load),
        .cnt        (cnt[r]),
        .cnt_next   (cnt_next[r]),
        .ld         (ld[r]),
        .underflow  (underflow_vec[r])
      );
    end
  end

  // An issue to a register already at its maximum count is dropped.
  assign issue_ready = (cnt[issue_wa] != CNT_MAX);

  // Source queries read registered state only; no same-cycle bypass.
  assign busy1   = (cnt[ra1] != '0);
  assign busy2   = (cnt[ra2] != '0);
  assign ldpend1 = busy1 & ld[ra1];
  assign ldpend2 = busy2 & ld[ra2];

  // Total follows the saturated per-register next counts, so it never drifts.
  always_comb begin
    total_next = '0;
    for (int r = 0; r < NREG; r++) begin
      total_next = total_next + TOT_W'(cnt_next[r]);
    end
  end

  // Outstanding total and sticky record of any release against an empty register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      total          <= '0;
      underflow_seen <= 1'b0;
    end else begin
      total          <= total_next;
      underflow_seen <= underflow_seen | (|underflow_vec);
    end
  end

  assign drained = (total == '0);

endmodule

// File: tb/tb_reg_scoreboard.sv
// Directed and model-checked stimulus for reg_scoreboard.
module tb_reg_scoreboard;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       issue_valid;
  logic [4:0] issue_wa;
  logic       issue_load;
  logic       issue_ready;
  logic       wb_valid;
  logic [4:0] wb_wa;
  logic       kill_valid;
  logic [4:0] kill_wa;
  logic [4:0] ra1;
  logic [4:0] ra2;
  logic       busy1;
  logic       busy2;
  logic       ldpend1;
  logic       ldpend2;
  logic       drained;
  logic       underflow_seen;

  int errors = 0;
  int checks = 0;

  int mcnt [32];
  bit mld  [32];

  always #5 clk = ~clk;

  reg_scoreboard dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .issue_valid    (issue_valid),
    .issue_wa       (issue_wa),
    .issue_load     (issue_load),
    .issue_ready    (issue_ready),
    .wb_valid       (wb_valid),
    .wb_wa          (wb_wa),
    .kill_valid     (kill_valid),
    .kill_wa        (kill_wa),
    .ra1            (ra1),
    .ra2            (ra2),
    .busy1          (busy1),
    .busy2          (busy2),
    .ldpend1        (ldpend1),
    .ldpend2        (ldpend2),
    .drained        (drained),
    .underflow_seen (underflow_seen)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    issue_valid = 1'b0;
    issue_load  = 1'b0;
    wb_valid    = 1'b0;
    kill_valid  = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time budget");
    $fatal(1, "watchdog");
  end

  initial begin
    int  tot;
    int  n;
    bit  acc;

    reset_n  = 1'b0;
    idle();
    issue_wa = '0;
    wb_wa    = '0;
    kill_wa  = '0;
    ra1      = '0;
    ra2      = '0;
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;

    // Reset state
    check("rst_busy1",   busy1,          0);
    check("rst_busy2",   busy2,          0);
    check("rst_ldpend1", ldpend1,        0);
    check("rst_drained", drained,        1);
    check("rst_ready",   issue_ready,    1);
    check("rst_uflow",   underflow_seen, 0);

    // Test 1: async reset mid-traffic with x5 holding two reservations
    issue_valid = 1'b1; issue_wa = 5'd5;
    cyc();
    cyc();
    idle();
    ra1 = 5'd5;
    #1;
    check("t1_busy_pre",    busy1,   1);
    check("t1_drained_pre", drained, 0);
    #2;
    reset_n = 1'b0;
    #1;
    check("t1_busy_rst",    busy1,       0);
    check("t1_drained_rst", drained,     1);
    check("t1_ready_rst",   issue_ready, 1);
    #1;
    reset_n = 1'b1;
    cyc();
    check("t1_busy_after", busy1, 0);

    // Test 2: load issue to x5, writeback three cycles later
    issue_valid = 1'b1; issue_wa = 5'd5; issue_load = 1'b1; ra1 = 5'd5;
    #1;
    check("t2_busy_t0", busy1, 0);
    cyc();
    idle();
    #1;
    check("t2_busy_t1",    busy1,   1);
    check("t2_ldpend_t1",  ldpend1, 1);
    check("t2_drained_t1", drained, 0);
    cyc();
    cyc();
    wb_valid = 1'b1; wb_wa = 5'd5;
    #1;
    check("t2_busy_t3", busy1, 1);
    cyc();
    idle();
    #1;
    check("t2_busy_t4",    busy1,   0);
    check("t2_ldpend_t4",  ldpend1, 0);
    check("t2_drained_t4", drained, 1);

    // Test 3: saturation on x7
    issue_valid = 1'b1; issue_wa = 5'd7; issue_load = 1'b0; ra1 = 5'd7;
    #1;
    check("t3_ready_0", issue_ready, 1);
    cyc();
    cyc();
    #1;
    check("t3_ready_2", issue_ready, 1);
    cyc();
    #1;
    check("t3_ready_full", issue_ready, 0);
    cyc();
    idle();
    wb_valid = 1'b1; wb_wa = 5'd7;
    #1;
    check("t3_ready_still_full", issue_ready, 0);
    cyc();
    #1;
    check("t3_ready_after_wb", issue_ready, 1);
    check("t3_busy_cnt2",      busy1,       1);
    cyc();
    #1;
    check("t3_busy_cnt1", busy1, 1);
    cyc();
    idle();
    #1;
    check("t3_busy_cnt0",    busy1,   0);
    check("t3_drained_cnt0", drained, 1);

    // Test 4: simultaneous issue/wb/kill on x9
    issue_valid = 1'b1; issue_wa = 5'd9; issue_load = 1'b0; ra1 = 5'd9;
    cyc();
    cyc();
    issue_load = 1'b1;
    wb_valid   = 1'b1; wb_wa   = 5'd9;
    kill_valid = 1'b1; kill_wa = 5'd9;
    cyc();
    idle();
    #1;
    check("t4_busy_3way",   busy1,   1);
    check("t4_ldpend_3way", ldpend1, 1);
    issue_valid = 1'b1; issue_wa = 5'd9; issue_load = 1'b0;
    wb_valid    = 1'b1; wb_wa    = 5'd9;
    cyc();
    idle();
    #1;
    check("t4_busy_2way",   busy1,   1);
    check("t4_ldpend_2way", ldpend1, 0);
    check("t4_drained_mid", drained, 0);
    wb_valid = 1'b1; wb_wa = 5'd9;
    cyc();
    idle();
    #1;
    check("t4_busy_end",    busy1,   0);
    check("t4_drained_end", drained, 1);

    // Test 5: everything addressed to x0 is ignored
    issue_valid = 1'b1; issue_wa = 5'd0; issue_load = 1'b1;
    wb_valid    = 1'b1; wb_wa    = 5'd0;
    kill_valid  = 1'b1; kill_wa  = 5'd0;
    ra1 = 5'd0; ra2 = 5'd0;
    #1;
    check("t5_ready_x0", issue_ready, 1);
    cyc();
    wb_valid = 1'b0; kill_valid = 1'b0;
    cyc();
    idle();
    #1;
    check("t5_busy1_x0",   busy1,   0);
    check("t5_busy2_x0",   busy2,   0);
    check("t5_ldpend2_x0", ldpend2, 0);
    check("t5_drained_x0", drained, 1);
    issue_valid = 1'b1; issue_wa = 5'd3; issue_load = 1'b1; ra2 = 5'd3;
    cyc();
    idle();
    #1;
    check("t5_busy2_x3",   busy2,   1);
    check("t5_ldpend2_x3", ldpend2, 1);
    check("t5_busy1_x0b",  busy1,   0);
    kill_valid = 1'b1; kill_wa = 5'd3;
    cyc();
    idle();
    #1;
    check("t5_busy2_killed", busy2,   0);
    check("t5_drained_end",  drained, 1);

    // Test 6: squash against an empty register
    check("t6_uflow_before", underflow_seen, 0);
    kill_valid = 1'b1; kill_wa = 5'd12; ra1 = 5'd12;
    cyc();
    idle();
    issue_wa = 5'd12;
    #1;
    check("t6_uflow_set", underflow_seen, 1);
    check("t6_busy",      busy1,          0);
    check("t6_drained",   drained,        1);
    check("t6_ready",     issue_ready,    1);
    issue_valid = 1'b1;
    cyc();
    idle();
    #1;
    check("t6_busy_one", busy1, 1);
    check("t6_ready_one", issue_ready, 1);
    wb_valid = 1'b1; wb_wa = 5'd12;
    cyc();
    idle();
    #1;
    check("t6_busy_clear", busy1, 0);

    // Fresh reset before the model-checked sequence
    #1;
    reset_n = 1'b0;
    #1;
    check("t6_uflow_reset", underflow_seen, 0);
    reset_n = 1'b1;
    cyc();
    for (int r = 0; r < 32; r++) begin
      mcnt[r] = 0;
      mld[r]  = 1'b0;
    end

    // Random traffic over a small register set, compared every cycle
    for (int i = 0; i < 300; i++) begin
      issue_valid = 1'($urandom_range(0, 1));
      issue_wa    = 5'($urandom_range(0, 4));
      issue_load  = 1'($urandom_range(0, 1));
      wb_valid    = ($urandom_range(0, 2) != 0);
      wb_wa       = 5'($urandom_range(0, 4));
      kill_valid  = ($urandom_range(0, 5) == 0);
      kill_wa     = 5'($urandom_range(0, 4));
      ra1         = 5'($urandom_range(0, 4));
      ra2         = 5'($urandom_range(0, 4));
      #1;
      tot = 0;
      for (int r = 0; r < 32; r++) tot += mcnt[r];
      check("rnd_ready",   issue_ready, (mcnt[issue_wa] != 3));
      check("rnd_busy1",   busy1,       (mcnt[ra1] != 0));
      check("rnd_busy2",   busy2,       (mcnt[ra2] != 0));
      check("rnd_ldpend1", ldpend1,     (mcnt[ra1] != 0) && mld[ra1]);
      check("rnd_ldpend2", ldpend2,     (mcnt[ra2] != 0) && mld[ra2]);
      check("rnd_drained", drained,     (tot == 0));
      acc = issue_valid && (mcnt[issue_wa] != 3) && (issue_wa != 0);
      cyc();
      for (int r = 1; r < 32; r++) begin
        n = mcnt[r];
        if (acc && issue_wa == 5'(r))         n++;
        if (wb_valid && wb_wa == 5'(r))       n--;
        if (kill_valid && kill_wa == 5'(r))   n--;
        if (n < 0) n = 0;
        if (n == 0)                           mld[r] = 1'b0;
        else if (acc && issue_wa == 5'(r))    mld[r] = issue_load;
        mcnt[r] = n;
      end
    end
    idle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
